// File: rtl/tx_pkg.sv
// Shared constants and types for the serial-frame transmit arbiter.
//   DATA_W     : default payload width of the frame transmitter
//   DIVISOR    : default clocks per serial bit
//   FRAME_BITS : bits on the line per frame (start + payload + stop)
//   tx_state_e : arbiter FSM states
package tx_pkg;

  localparam int unsigned DATA_W     = 162;
  localparam int unsigned DIVISOR    = 10416;
  localparam int unsigned FRAME_BITS = DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT
  } tx_state_e;

endpackage

// File: rtl/tx_rr_picker.sv
// Combinational round-robin picker.
//   eligible_in : one bit per requester, 1 = may be granted
//   ptr_in      : highest-priority index for this pick
//   valid_out   : at least one requester is eligible
//   win_out     : first eligible index at or after ptr_in, wrapping
module tx_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] eligible_in,
  input  logic [IDX_W-1:0]   ptr_in,
  output logic               valid_out,
  output logic [IDX_W-1:0]   win_out
);

  import tx_pkg::*;

  // Rotate so bit 0 is the requester at the pointer; offset k maps to (ptr + k) mod NUM_REQ.
  logic [NUM_REQ-1:0] rotated;
  assign rotated = NUM_REQ'({eligible_in, eligible_in} >> ptr_in);

  always_comb begin
    valid_out = |eligible_in;
    win_out   = '0;
    // Scan from the farthest offset down so the nearest eligible one is written last.
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      if (((rotated >> off) & NUM_REQ'(1)) != '0) begin
        win_out = IDX_W'((int'(ptr_in) + off) % int'(NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial frame transmitter among NUM_REQ requesters.
// The transmitter has no busy flag, so the frame is timed locally after the trigger.
//   clk_in       : system clock
//   rst_in       : synchronous active-high reset
//   req_in       : level request per requester
//   mask_in      : 1 = requester enabled
//   data_in      : payloads, requester i owns [i*DATA_W +: DATA_W]
//   ack_out      : one-cycle pulse, payload of requester i captured
//   trigger_out  : one-cycle start pulse to the transmitter
//   val_out      : captured payload, held for the whole frame
//   busy_out     : high from capture until the frame window ends
//   grant_id_out : index of the current or last granted requester
//   done_out     : one-cycle pulse when the frame window ends
module tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DATA_W       = tx_pkg::DATA_W,
  parameter int unsigned DIVISOR      = tx_pkg::DIVISOR,
  parameter int unsigned FRAME_CYCLES = DIVISOR * (DATA_W + 3),
  parameter int unsigned CNT_W        = $clog2(FRAME_CYCLES),
  parameter int unsigned IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_REQ-1:0]          req_in,
  input  logic [NUM_REQ-1:0]          mask_in,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]          ack_out,
  output logic                        trigger_out,
  output logic [DATA_W-1:0]           val_out,
  output logic                        busy_out,
  output logic [IDX_W-1:0]            grant_id_out,
  output logic                        done_out
);

  import tx_pkg::*;

  tx_state_e            state_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 trig_q;
  logic [DATA_W-1:0]    val_q;
  logic                 busy_q;
  logic [IDX_W-1:0]     grant_q;
  logic                 done_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     timer_q;

  logic [NUM_REQ-1:0]   eligible;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [DATA_W-1:0]    pick_data;
  logic [IDX_W-1:0]     ptr_next;

  assign eligible = req_in & mask_in;

  tx_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .eligible_in (eligible),
    .ptr_in      (ptr_q),
    .valid_out   (pick_valid),
    .win_out     (pick_idx)
  );

  // Constant-select payload mux keeps the index width clean.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_idx == IDX_W'(i)) pick_data = data_in[i*DATA_W +: DATA_W];
    end
  end

  assign ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      ack_q   <= '0;
      trig_q  <= 1'b0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      // Pulses default low every cycle so they can never be held.
      ack_q  <= '0;
      trig_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            val_q          <= pick_data;
            ack_q          <= NUM_REQ'(1) << pick_idx;
            grant_q        <= pick_idx;
            busy_q         <= 1'b1;
            ptr_q          <= ptr_next;
            state_q        <= TRIG;
          end
        end
        TRIG: begin
          trig_q  <= 1'b1;
          timer_q <= CNT_W'(FRAME_CYCLES - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (timer_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_out      = ack_q;
  assign trigger_out  = trig_q;
  assign val_out      = val_q;
  assign busy_out     = busy_q;
  assign grant_id_out = grant_q;
  assign done_out     = done_q;

endmodule

// File: tb/tb_tx_arbiter.sv
module tb_tx_arbiter;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DIVISOR  = 4;
  localparam int          FRAME    = 44;

  logic                      clk_in = 1'b0;
  logic                      rst_in;
  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ-1:0]        mask_in;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        ack_out;
  logic                      trigger_out;
  logic [DATA_W-1:0]         val_out;
  logic                      busy_out;
  logic [0:0]                grant_id_out;
  logic                      done_out;

  tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .DIVISOR (DIVISOR)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_in       (req_in),
    .mask_in      (mask_in),
    .data_in      (data_in),
    .ack_out      (ack_out),
    .trigger_out  (trigger_out),
    .val_out      (val_out),
    .busy_out     (busy_out),
    .grant_id_out (grant_id_out),
    .done_out     (done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0] ack;
    logic [7:0] data;
    logic [0:0] gid;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   trig_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int last_ack_cyc = 0;
  int last_trig_cyc = 0;
  int last_done_cyc = 0;
  bit trig_pend = 0;
  bit frame_pend = 0;
  bit val_bad = 0;
  logic [7:0] cur_val = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every ack and times trigger/done against it.
  always @(negedge clk_in) begin
    if (rst_in) begin
      trig_pend  = 0;
      frame_pend = 0;
    end else begin
      if (ack_out != '0) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got ack=%b val=%h gid=%0d, required no ack",
                   ack_out, val_out, grant_id_out);
        end else begin
          mon_e = exp_q.pop_front();
          if ({ack_out, val_out, grant_id_out} !== mon_e) begin
            errors++;
            $display("FAIL grant: got ack=%b val=%h gid=%0d, required ack=%b val=%h gid=%0d",
                     ack_out, val_out, grant_id_out, mon_e.ack, mon_e.data, mon_e.gid);
          end
        end
        cur_val   = val_out;
        trig_pend = 1;
        val_bad   = 0;
      end else if (busy_out && val_out !== cur_val) begin
        val_bad = 1;
      end
      if (trigger_out) begin
        trig_cnt++;
        checks++;
        if (!trig_pend || cyc != last_ack_cyc + 1) begin
          errors++;
          $display("FAIL trigger_timing: got trigger at cycle %0d, required cycle %0d after ack",
                   cyc, last_ack_cyc + 1);
        end
        trig_pend     = 0;
        frame_pend    = 1;
        last_trig_cyc = cyc;
        trig_log.push_back(cyc);
      end
      if (done_out) begin
        done_cnt++;
        checks++;
        if (!frame_pend || cyc != last_trig_cyc + FRAME) begin
          errors++;
          $display("FAIL done_timing: got done at cycle %0d (frame pending %0d), required cycle %0d",
                   cyc, frame_pend, last_trig_cyc + FRAME);
        end
        checks++;
        if (val_bad) begin
          errors++;
          $display("FAIL val_stable: got val_out change mid-frame, required held %h", cur_val);
        end
        frame_pend    = 0;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_acks(input int target, input string name);
    int n = 0;
    while (ack_cnt < target && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    check(name, ack_cnt, target);
  endtask

  task automatic wait_trig(input int target, input string name);
    int n = 0;
    while (trig_cnt < target && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    check(name, trig_cnt, target);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_out !== 1'b0 || frame_pend) && n < 600) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL %s: got still busy after %0d cycles, required idle", name, n);
    end
  endtask

  int b;
  int t;
  int d;

  initial begin
    rst_in  = 1'b1;
    req_in  = '0;
    mask_in = 2'b11;
    data_in = '0;
    tick(3);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("reset_ack", ack_out, 0);
    check("reset_trigger", trigger_out, 0);
    check("reset_val", val_out, 0);
    check("reset_busy", busy_out, 0);
    check("reset_gid", grant_id_out, 0);
    check("reset_done", done_out, 0);

    // Single request from requester 0.
    tick(1);
    data_in = {8'h00, 8'hA5};
    exp_q.push_back('{ack: 2'b01, data: 8'hA5, gid: 1'b0});
    req_in = 2'b01;
    wait_acks(1, "single_ack");
    tick(1);
    req_in = '0;
    wait_idle("single_idle");
    check("single_done_count", done_cnt, 1);

    // Both held from pointer 0: grants alternate, triggers 46 cycles apart.
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    trig_log.delete();
    data_in = {8'h22, 8'h11};
    exp_q.push_back('{ack: 2'b01, data: 8'h11, gid: 1'b0});
    exp_q.push_back('{ack: 2'b10, data: 8'h22, gid: 1'b1});
    exp_q.push_back('{ack: 2'b01, data: 8'h11, gid: 1'b0});
    exp_q.push_back('{ack: 2'b10, data: 8'h22, gid: 1'b1});
    b = ack_cnt;
    req_in = 2'b11;
    wait_acks(b + 4, "rr_acks");
    tick(1);
    req_in = '0;
    wait_idle("rr_idle");
    check("rr_trig_count", trig_log.size(), 4);
    for (int i = 1; i < trig_log.size(); i++) begin
      check("rr_trig_spacing", trig_log[i] - trig_log[i-1], 46);
    end

    // Requester 1 raises during requester 0's frame; served right after done.
    data_in = {8'h44, 8'h33};
    exp_q.push_back('{ack: 2'b01, data: 8'h33, gid: 1'b0});
    b = ack_cnt;
    req_in = 2'b01;
    wait_acks(b + 1, "late_first_ack");
    tick(1);
    req_in = '0;
    tick(10);
    exp_q.push_back('{ack: 2'b10, data: 8'h44, gid: 1'b1});
    req_in = 2'b10;
    check("late_val_held", val_out, 8'h33);
    wait_acks(b + 2, "late_second_ack");
    check("late_ack_after_done", last_ack_cyc - last_done_cyc, 1);
    tick(1);
    req_in = '0;
    wait_idle("late_idle");

    // Requester 0 masked: only requester 1 is ever acked.
    mask_in = 2'b10;
    data_in = {8'h66, 8'h55};
    exp_q.push_back('{ack: 2'b10, data: 8'h66, gid: 1'b1});
    exp_q.push_back('{ack: 2'b10, data: 8'h66, gid: 1'b1});
    b = ack_cnt;
    req_in = 2'b11;
    wait_acks(b + 2, "mask_acks");
    tick(1);
    req_in = '0;
    wait_idle("mask_idle");
    mask_in = 2'b11;

    // Reset 10 cycles into the wait window abandons the frame.
    data_in = {8'h88, 8'h77};
    exp_q.push_back('{ack: 2'b01, data: 8'h77, gid: 1'b0});
    t = trig_cnt;
    req_in = 2'b01;
    wait_trig(t + 1, "abort_trigger");
    tick(1);
    req_in = '0;
    tick(9);
    d = done_cnt;
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("abort_busy", busy_out, 0);
    check("abort_trigger_low", trigger_out, 0);
    check("abort_val", val_out, 0);
    tick(50);
    check("abort_no_done", done_cnt, d);
    exp_q.push_back('{ack: 2'b10, data: 8'h88, gid: 1'b1});
    b = ack_cnt;
    req_in = 2'b10;
    wait_acks(b + 1, "abort_fresh_ack");
    tick(1);
    req_in = '0;
    wait_idle("abort_fresh_idle");

    // One-cycle request during the wait window is lost.
    data_in = {8'h99, 8'h5A};
    exp_q.push_back('{ack: 2'b10, data: 8'h99, gid: 1'b1});
    b = ack_cnt;
    t = trig_cnt;
    req_in = 2'b10;
    wait_trig(t + 1, "drop_trigger");
    tick(1);
    req_in = '0;
    tick(5);
    req_in = 2'b01;
    tick(1);
    req_in = '0;
    wait_idle("drop_idle");
    tick(10);
    check("drop_ack_count", ack_cnt, b + 1);
    check("drop_trig_count", trig_cnt, t + 1);
    check("drop_busy", busy_out, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
